// File: rtl/swc_rtu_gen_pkg.sv
// Shared types and constants for the swcore RTU response generator.
// Holds the destination-mode enum, port FSM states, LFSR taps and the RR step helper.
package swc_rtu_gen_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'd0,
        RR    = 2'd1,
        BCAST = 2'd2,
        RAND  = 2'd3
    } t_rtu_gen_mode;

    typedef enum logic {
        IDLE  = 1'b0,
        VALID = 1'b1
    } t_rtu_gen_state;

    // x^16+x^14+x^13+x^11+1 in right-shift form: feedback from bits 0,2,3,5
    // enters at bit 15.
    localparam logic [15:0] c_rtu_gen_lfsr_taps = 16'h002D;

    // Next round-robin target: step by one, wrap at n, never land on src.
    function automatic logic [3:0] f_rr_next(
        input logic [3:0] cur,
        input logic [3:0] src,
        input logic [4:0] n
    );
        logic [3:0] nxt;
        nxt = ((5'(cur) + 5'd1) >= n) ? 4'd0 : cur + 4'd1;
        if (nxt == src) begin
            nxt = ((5'(nxt) + 5'd1) >= n) ? 4'd0 : nxt + 4'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/swc_rtu_gen_port.sv
// One port of the RTU response generator: pending counter, IDLE/VALID FSM,
// round-robin pointer, drop counter and priority sequence.
// Ports: i_clk, i_rst_n, i_sof, i_ack, i_mode, i_fixed_mask, i_drop_every,
// i_lfsr (shared LFSR slice) -> o_valid, o_mask, o_drop, o_prio, o_overflow.
module swc_rtu_gen_port
    import swc_rtu_gen_pkg::*;
#(
    parameter int g_port        = 0,
    parameter int g_num_ports   = 11,
    parameter int g_prio_width  = 3,
    parameter int g_queue_depth = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_sof,
    input  logic                    i_ack,
    input  t_rtu_gen_mode           i_mode,
    input  logic [g_num_ports-1:0]  i_fixed_mask,
    input  logic [7:0]              i_drop_every,
    input  logic [g_num_ports-1:0]  i_lfsr,
    output logic                    o_valid,
    output logic [g_num_ports-1:0]  o_mask,
    output logic                    o_drop,
    output logic [g_prio_width-1:0] o_prio,
    output logic                    o_overflow
);

    localparam int c_cw = $clog2(g_queue_depth + 1);
    localparam logic [c_cw-1:0] c_full = c_cw'(g_queue_depth);
    localparam logic [3:0] c_src = 4'(g_port);
    localparam logic [3:0] c_rr_rst = 4'((g_port + 1) % g_num_ports);
    localparam logic [4:0] c_n = 5'(g_num_ports);
    localparam logic [g_num_ports-1:0] c_own = g_num_ports'(1) << g_port;

    t_rtu_gen_state r_state;
    t_rtu_gen_state w_state_nxt;

    logic [c_cw-1:0]         r_pend;
    logic                    r_ovf;
    logic [3:0]              r_rr;
    logic [7:0]              r_dc;
    logic [7:0]              r_seq;
    logic [g_num_ports-1:0]  r_mask;
    logic                    r_drop;
    logic [g_prio_width-1:0] r_prio;

    logic                    w_hs;
    logic                    w_accept;
    logic                    w_latch;
    logic [g_num_ports-1:0]  w_rr_mask;
    logic [g_num_ports-1:0]  w_rand;
    logic [g_num_ports-1:0]  w_mask;
    logic                    w_use_rr;
    logic [8:0]              w_dc_inc;
    logic                    w_drop;

    assign w_hs     = (r_state == VALID) & i_ack;
    // A full queue still takes a pulse when an ack frees a slot that cycle.
    assign w_accept = i_sof & ((r_pend != c_full) | w_hs);
    assign w_latch  = (r_state == IDLE) & (r_pend != '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pend <= '0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_accept & ~w_hs) begin
                r_pend <= r_pend + c_cw'(1);
            end else if (~w_accept & w_hs) begin
                r_pend <= r_pend - c_cw'(1);
            end
            if (i_sof & ~w_accept) begin
                r_ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (w_latch) w_state_nxt = VALID;
            VALID:   if (i_ack)   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_valid    = (r_state == VALID);
        o_mask     = r_mask;
        o_drop     = r_drop;
        o_prio     = r_prio;
        o_overflow = r_ovf;
    end

    assign w_rr_mask = g_num_ports'(1) << r_rr;
    assign w_rand    = i_lfsr & ~c_own;

    always_comb begin
        w_mask   = '0;
        w_use_rr = 1'b0;
        unique case (i_mode)
            FIXED: w_mask = i_fixed_mask & ~c_own;
            RR: begin
                w_mask   = w_rr_mask;
                w_use_rr = 1'b1;
            end
            BCAST: w_mask = ~c_own;
            RAND: begin
                // An all-zero random mask falls back to round-robin.
                if (w_rand != '0) begin
                    w_mask = w_rand;
                end else begin
                    w_mask   = w_rr_mask;
                    w_use_rr = 1'b1;
                end
            end
            default: w_mask = '0;
        endcase
    end

    // >= rather than == so lowering drop_every mid-run cannot strand dc.
    assign w_dc_inc = {1'b0, r_dc} + 9'd1;
    assign w_drop   = (i_drop_every != 8'd0) &&
                      (w_dc_inc >= {1'b0, i_drop_every});

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mask <= '0;
            r_drop <= 1'b0;
            r_prio <= '0;
            r_rr   <= c_rr_rst;
            r_dc   <= '0;
            r_seq  <= '0;
        end else begin
            if (i_drop_every == 8'd0) begin
                r_dc <= '0;
            end
            if (w_latch) begin
                r_mask <= w_mask;
                r_drop <= w_drop;
                r_prio <= g_prio_width'(r_seq);
                r_seq  <= r_seq + 8'd1;
                if (w_use_rr) begin
                    r_rr <= f_rr_next(r_rr, c_src, c_n);
                end
                if (i_drop_every != 8'd0) begin
                    r_dc <= w_drop ? 8'd0 : w_dc_inc[7:0];
                end
            end
        end
    end

endmodule

// File: rtl/swc_rtu_rsp_gen.sv
// RTU response generator: one response per packet start on each swcore port.
// Inputs: clk_i, rst_n_i, pck_sof_i, mode_i, fixed_mask_i, drop_every_i, rtu_rsp_ack_i.
// Outputs: rtu_rsp_valid_o, rtu_dst_port_mask_o, rtu_drop_o, rtu_prio_o, req_overflow_o,
// and rsp_cnt_o (acked-response counters) when SWC_RTU_GEN_STATS_EN is defined.
module swc_rtu_rsp_gen
    import swc_rtu_gen_pkg::*;
#(
    parameter int          g_num_ports   = 11,
    parameter int          g_prio_width  = 3,
    parameter int          g_queue_depth = 4,
    parameter logic [15:0] g_seed        = 16'hACE1
) (
    input  logic                                clk_i,
    input  logic                                rst_n_i,
    input  logic [g_num_ports-1:0]              pck_sof_i,
    input  logic [1:0]                          mode_i,
    input  logic [g_num_ports-1:0]              fixed_mask_i,
    input  logic [7:0]                          drop_every_i,
    output logic [g_num_ports-1:0]              rtu_rsp_valid_o,
    input  logic [g_num_ports-1:0]              rtu_rsp_ack_i,
    output logic [g_num_ports*g_num_ports-1:0]  rtu_dst_port_mask_o,
    output logic [g_num_ports-1:0]              rtu_drop_o,
    output logic [g_num_ports*g_prio_width-1:0] rtu_prio_o,
    output logic [g_num_ports-1:0]              req_overflow_o
`ifdef SWC_RTU_GEN_STATS_EN
    ,
    output logic [g_num_ports*16-1:0]           rsp_cnt_o
`endif
);

    localparam int N = g_num_ports;
    localparam int P = g_prio_width;

    logic [15:0]   r_lfsr;
    logic          w_lfsr_fb;
    t_rtu_gen_mode w_mode;

    assign w_mode    = t_rtu_gen_mode'(mode_i);
    assign w_lfsr_fb = ^(r_lfsr & c_rtu_gen_lfsr_taps);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_lfsr <= g_seed;
        end else begin
            r_lfsr <= {w_lfsr_fb, r_lfsr[15:1]};
        end
    end

    for (genvar p = 0; p < N; p++) begin : g_ports
        swc_rtu_gen_port #(
            .g_port        (p),
            .g_num_ports   (N),
            .g_prio_width  (P),
            .g_queue_depth (g_queue_depth)
        ) u_port (
            .i_clk        (clk_i),
            .i_rst_n      (rst_n_i),
            .i_sof        (pck_sof_i[p]),
            .i_ack        (rtu_rsp_ack_i[p]),
            .i_mode       (w_mode),
            .i_fixed_mask (fixed_mask_i),
            .i_drop_every (drop_every_i),
            .i_lfsr       (r_lfsr[N-1:0]),
            .o_valid      (rtu_rsp_valid_o[p]),
            .o_mask       (rtu_dst_port_mask_o[p*N +: N]),
            .o_drop       (rtu_drop_o[p]),
            .o_prio       (rtu_prio_o[p*P +: P]),
            .o_overflow   (req_overflow_o[p])
        );
    end

`ifdef SWC_RTU_GEN_STATS_EN
    for (genvar p = 0; p < N; p++) begin : g_stats
        logic [15:0] r_cnt;
        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                r_cnt <= '0;
            end else if (rtu_rsp_valid_o[p] & rtu_rsp_ack_i[p] &
                         (r_cnt != 16'hFFFF)) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
        assign rsp_cnt_o[p*16 +: 16] = r_cnt;
    end
`endif

endmodule
